// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite read arbiter.
package axi_lite_arb_pkg;

  localparam int DEFAULT_WIDTH_ADDR = 32;
  localparam int DEFAULT_WIDTH_DATA = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);

  localparam int SW = ID_W + 1;

  logic [SW-1:0]   sum;
  logic [ID_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    grant = '0;
    id    = '0;
    sum   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      cand = sum[ID_W-1:0];
      if (req[cand]) id = cand;
    end
    if (|req) grant[id] = 1'b1;
  end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// Shares one AXI4-Lite read-master port among NUM_REQ requesters, round-robin,
// one read outstanding, with a watchdog that answers DECERR for reads that hang.
module axi_lite_read_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_ADDR = DEFAULT_WIDTH_ADDR,
  parameter int WIDTH_DATA = DEFAULT_WIDTH_DATA,
  parameter int TIMEOUT    = 256,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WIDTH_ADDR-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH_DATA-1:0]         rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic                          read_en,
  output logic [WIDTH_ADDR-1:0]         read_addr_in,
  input  logic [WIDTH_DATA-1:0]         read_data_out,
  input  logic [1:0]                    read_response_out,
  input  logic                          read_done,
  output arb_state_t                    debug_state,
  output logic [ID_W-1:0]               debug_rr_ptr
);

  // Handshake: a request transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both high; responses are one-cycle pulses with no back-pressure.

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t         state, next_state;
  logic [ID_W-1:0]    rr_ptr, cur_id, win_id, next_ptr;
  logic [NUM_REQ-1:0] win_grant, owner;
  logic [WIDTH_ADDR-1:0] win_addr;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               grant_now, timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .id    (win_id)
  );

  assign grant_now    = (state == IDLE) && (|req_valid);
  assign req_ready    = (state == IDLE && !reset) ? win_grant : '0;
  assign next_ptr     = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
  assign owner        = NUM_REQ'(1) << cur_id;
  assign debug_state  = state;
  assign debug_rr_ptr = rr_ptr;

  // Counter is cleared in ISSUE and counts WAIT cycles; firing one short of
  // TIMEOUT-1 on the pre-increment value bounds ISSUE+WAIT to TIMEOUT cycles.
  assign timeout_hit = (state == WAIT) && (tmo_cnt == CNT_W'(TIMEOUT - 2));

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_grant[i]) win_addr = req_addr[i*WIDTH_ADDR +: WIDTH_ADDR];
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (grant_now) next_state = ISSUE;
      ISSUE:   next_state = read_done ? RESP : WAIT;
      WAIT:    if (read_done || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      tmo_cnt      <= '0;
      read_en      <= 1'b0;
      read_addr_in <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_resp     <= '0;
    end else begin
      state     <= next_state;
      read_en   <= 1'b0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (grant_now) begin
            cur_id       <= win_id;
            read_addr_in <= win_addr;
            rr_ptr       <= next_ptr;
            read_en      <= 1'b1;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          if (read_done) begin
            rsp_valid <= owner;
            rsp_data  <= read_data_out;
            rsp_resp  <= read_response_out;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A completion landing on the watchdog cycle still carries the slave's answer.
          if (read_done) begin
            rsp_valid <= owner;
            rsp_data  <= read_data_out;
            rsp_resp  <= read_response_out;
          end else if (timeout_hit) begin
            rsp_valid <= owner;
            rsp_data  <= '0;
            rsp_resp  <= RESP_DECERR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Bench for axi_lite_read_arbiter: reference arbitration model, slave model and
// an expected-response queue checked every cycle on the falling edge.
module tb_axi_lite_read_arbiter;
  import axi_lite_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WA      = 32;
  localparam int WD      = 32;
  localparam int TIMEOUT = 8;
  localparam int ID_W    = 2;
  localparam int EXP_W   = 32 + NUM_REQ + 2 + WD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid;
  logic [NUM_REQ*WA-1:0] req_addr;
  logic [WD-1:0]         rsp_data, read_data_out;
  logic [1:0]            rsp_resp, read_response_out;
  logic                  read_en, read_done;
  logic [WA-1:0]         read_addr_in;
  arb_state_t            debug_state;
  logic [ID_W-1:0]       debug_rr_ptr;

  axi_lite_read_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .read_en(read_en), .read_addr_in(read_addr_in),
    .read_data_out(read_data_out), .read_response_out(read_response_out),
    .read_done(read_done),
    .debug_state(debug_state), .debug_rr_ptr(debug_rr_ptr)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0]   exp_q[$];
  logic [NUM_REQ-1:0] glog[$];
  int                 gcyc[$];
  int n_checks, n_fail, cyc;
  bit m_busy;
  int m_ptr, m_grant_cyc;
  logic [WA-1:0] m_addr;
  int sl_lat, sl_cnt;
  logic [WD-1:0] sl_data;
  logic [1:0] sl_resp;
  bit hold_req, rand_data;
  logic [NUM_REQ-1:0] acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (ptr + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  // ---------------- per-cycle model, monitor and slave driver ----------------
  task automatic tick();
    logic [NUM_REQ-1:0] exp_ready;
    logic [EXP_W-1:0]   e;
    logic [31:0]        due;
    int id;
    id = 0;
    @(negedge clk);
    acc = req_valid & req_ready;
    if (acc != '0) begin
      glog.push_back(acc);
      gcyc.push_back(cyc);
    end
    if (reset) begin
      check_eq("ready_in_reset", req_ready, '0);
      m_busy = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
      sl_cnt = -1;
    end else begin
      exp_ready = '0;
      if (!m_busy && req_valid != '0) begin
        id = rr_pick(req_valid, m_ptr);
        exp_ready[id] = 1'b1;
      end
      check_eq("req_ready", req_ready, exp_ready);
      check_eq("read_en", read_en, (m_busy && cyc == m_grant_cyc + 1) ? 64'd1 : 64'd0);
      due = (exp_q.size() > 0) ? exp_q[0][EXP_W-1 -: 32] : '1;
      if (m_busy && cyc > m_grant_cyc && cyc != int'(due))
        check_eq("read_addr_in", read_addr_in, m_addr);
      if (exp_q.size() > 0 && int'(due) == cyc) begin
        e = exp_q.pop_front();
        check_eq("rsp_valid", rsp_valid, e[WD+2 +: NUM_REQ]);
        check_eq("rsp_data", rsp_data, e[WD-1:0]);
        check_eq("rsp_resp", rsp_resp, e[WD +: 2]);
        m_busy = 1'b0;
      end else begin
        check_eq("rsp_valid_quiet", rsp_valid, '0);
      end
      if (exp_ready != '0) begin
        m_busy      = 1'b1;
        m_ptr       = (id + 1) % NUM_REQ;
        m_grant_cyc = cyc;
        m_addr      = req_addr[id*WA +: WA];
        if (rand_data) sl_data = $urandom;
        if (sl_lat < 0 || sl_lat > TIMEOUT - 1)
          exp_q.push_back({32'(cyc + TIMEOUT + 1), NUM_REQ'(1 << id), RESP_DECERR, WD'(0)});
        else
          exp_q.push_back({32'(cyc + sl_lat + 2), NUM_REQ'(1 << id), sl_resp, sl_data});
      end
    end
    // slave: completes sl_lat cycles after the read_en cycle (sl_lat < 0: never)
    if (read_en) sl_cnt = sl_lat;
    else if (sl_cnt > 0) sl_cnt = sl_cnt - 1;
    else sl_cnt = -1;
    if (sl_cnt == 0) begin
      read_done         = 1'b1;
      read_data_out     = sl_data;
      read_response_out = sl_resp;
    end else begin
      read_done         = 1'b0;
      read_data_out     = $urandom;
      read_response_out = 2'($urandom_range(0, 3));
    end
    @(posedge clk);
    cyc++;
    #1;
    if (!hold_req) req_valid = req_valid & ~acc;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0 || req_valid != '0) && n < limit) begin
      tick();
      n++;
    end
    check_eq("idle_reached", {m_busy, 31'(exp_q.size())}, '0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rsp_valid"}, rsp_valid, '0);
    check_eq({tag, "_rsp_data"}, rsp_data, '0);
    check_eq({tag, "_rsp_resp"}, rsp_resp, '0);
    check_eq({tag, "_read_en"}, read_en, '0);
    check_eq({tag, "_read_addr_in"}, read_addr_in, '0);
    check_eq({tag, "_state"}, debug_state, IDLE);
    check_eq({tag, "_rr_ptr"}, debug_rr_ptr, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst");
  endtask

  task automatic wait_grants(input int count, input int limit);
    int n;
    n = 0;
    while (glog.size() < count && n < limit) begin
      tick();
      n++;
    end
    check_eq("grant_count", glog.size(), count);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    req_valid = '0; req_addr = '0;
    read_done = 1'b0; read_data_out = '0; read_response_out = '0;
    hold_req = 1'b0; rand_data = 1'b0;
    sl_lat = -1; sl_cnt = -1; sl_data = '0; sl_resp = '0;
    n_checks = 0; n_fail = 0; cyc = 0;
    m_busy = 1'b0; m_ptr = 0; m_grant_cyc = -10; m_addr = '0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("init");

    // single request, late data change must not leak
    sl_lat = 3; sl_data = 32'hDEAD_BEEF; sl_resp = RESP_OKAY;
    req_addr[2*WA +: WA] = 32'h40;
    req_valid = 4'b0100;
    tick();
    req_addr[2*WA +: WA] = 32'h99;
    wait_idle(50);

    // fairness with all requesters held
    do_reset();
    glog.delete(); gcyc.delete();
    req_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0100};
    rand_data = 1'b1; sl_lat = 1; sl_resp = RESP_OKAY;
    hold_req = 1'b1; req_valid = 4'hF;
    wait_grants(5, 100);
    hold_req = 1'b0; req_valid = '0;
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) check_eq($sformatf("fair_grant%0d", i), glog[i], 64'(1 << (i % 4)));
    for (int i = 1; i < 5; i++)
      if (i < gcyc.size()) check_eq($sformatf("fair_space%0d", i), (gcyc[i] - gcyc[i-1]) >= 3, 1);
    wait_idle(50);

    // zero-wait slave: back-to-back grants 3 cycles apart
    glog.delete(); gcyc.delete();
    sl_lat = 0;
    hold_req = 1'b1; req_valid = 4'b0011;
    wait_grants(3, 50);
    hold_req = 1'b0; req_valid = '0;
    for (int i = 1; i < 3; i++)
      if (i < gcyc.size()) check_eq($sformatf("zw_space%0d", i), gcyc[i] - gcyc[i-1], 3);
    wait_idle(50);

    // watchdog, then a late completion that must be dropped
    rand_data = 1'b0;
    sl_lat = 12; sl_data = 32'hFFFF_FFFF; sl_resp = RESP_OKAY;
    req_addr[1*WA +: WA] = 32'h1234;
    req_valid = 4'b0010;
    wait_idle(50);
    repeat (15) tick();

    // slave error passthrough
    sl_lat = 2; sl_data = 32'hBAD0_0001; sl_resp = RESP_SLVERR;
    req_valid = 4'b0001;
    wait_idle(50);

    // completion on the watchdog cycle wins
    sl_lat = TIMEOUT - 1; sl_data = 32'h1234_5678; sl_resp = RESP_OKAY;
    req_valid = 4'b0001;
    wait_idle(50);

    // reset while waiting on the slave
    sl_lat = -1;
    req_valid = 4'b0010;
    repeat (3) tick();
    check_eq("pre_reset_state", debug_state, WAIT);
    reset = 1'b1; req_valid = 4'b0110; sl_lat = 1;
    tick();
    reset = 1'b0;
    check_reset_state("midread");
    glog.delete(); gcyc.delete();
    tick();
    check_eq("post_reset_grant", (glog.size() > 0) ? glog[0] : '0, 4'b0010);
    wait_idle(50);

    // random traffic, latencies up to past the watchdog
    rand_data = 1'b1;
    for (int it = 0; it < 60; it++) begin
      if (!m_busy) begin
        sl_lat  = $urandom_range(0, 9);
        sl_resp = 2'($urandom_range(0, 3));
      end
      req_valid = req_valid | NUM_REQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      req_addr  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    wait_idle(300);
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_read_arbiter.md
# axi_lite_read_arbiter

Shares the single AXI4-Lite read-master port (read_en / read_addr_in / read_data_out / read_response_out / read_done) among NUM_REQ internal requesters. Requests are granted round-robin, one read is outstanding at a time, and a response is returned to the owning requester only. A watchdog terminates reads that never complete. The block sits between the requesters and the read side of the AXI4-Lite master.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- WIDTH_ADDR, `WIDTH_ADDR: address width, taken from top_define.svh
- WIDTH_DATA, `WIDTH_DATA: data width, taken from top_define.svh
- TIMEOUT, 256: maximum cycles spent in ISSUE+WAIT before the watchdog fires; must be ≥ 2
- One clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ×WIDTH_ADDR  per-requester address, packed with requester i at [i*WIDTH_ADDR +: WIDTH_ADDR]
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i]
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
- rsp_data  out  WIDTH_DATA  read data, qualified by rsp_valid
- rsp_resp  out  2  AXI response, qualified by rsp_valid
- read_en  out  1  one-cycle pulse that starts a read on the master port
- read_addr_in  out  WIDTH_ADDR  address to the master port; held from ISSUE until the end of WAIT
- read_data_out  in  WIDTH_DATA  data from the master port, valid with read_done
- read_response_out  in  2  response from the master port, valid with read_done
- read_done  in  1  completion pulse from the master port

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - The rr_arbiter picks the first asserted req_valid at or after rr_ptr, wrapping around.
  - req_ready is asserted combinationally for the winner only, and only while in IDLE.
  - On a grant: latch the winner's id and address, set rr_ptr = (id+1) mod NUM_REQ, go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE**
  - read_en = 1 for exactly this cycle; clear the timeout counter.
  - Go to WAIT, or directly to RESP if read_done is already high this cycle.
- **WAIT**
  - Increment the timeout counter each cycle.
  - On read_done: latch read_data_out and read_response_out, go to RESP.
- **Watchdog**
  - Fires when the counter reaches TIMEOUT-1 with no read_done.
  - Latches data = 0 and resp = 2'b11 (DECERR), then goes to RESP.
  - If read_done and the timeout occur in the same cycle, read_done wins.
- **RESP**
  - rsp_valid[id] = 1 for one cycle, driving the latched rsp_data and rsp_resp.
  - Requesters cannot stall the response; go to IDLE.
- read_done is ignored in IDLE and in RESP. A late completion after a watchdog timeout is therefore dropped.
- req_addr is sampled only in the grant cycle; later changes have no effect.
- **Reset** (valid in any state, including mid-read)
  - FSM returns to IDLE, rr_ptr = 0, timeout counter = 0.
  - The in-flight read is abandoned and no rsp_valid is produced for it.

## Timing
- All outputs are registered, except req_ready, which is a combinational function of req_valid, rr_ptr and state.
- Reset values: req_ready = 0 while reset is high, rsp_valid = 0, rsp_data = 0, rsp_resp = 0, read_en = 0, read_addr_in = 0.
- Fastest transaction, counting from the grant cycle T:
  - T: grant.
  - T+1: read_en high; read_done may also arrive in this cycle.
  - T+2: rsp_valid.
  - T+3: next grant possible.
- General latency: grant at T, read_done at cycle D ≥ T+1, rsp_valid at D+1. Minimum grant-to-grant spacing is 3 cycles.
- Timeout: rsp_valid with DECERR occurs at T+TIMEOUT+1.

## Structure
- Package axi_lite_arb_pkg contains:
  - the state enum typedef (IDLE, ISSUE, WAIT, RESP);
  - response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
- One sub-module, rr_arbiter: a parameterised NUM_REQ round-robin priority picker.
  - Inputs: req, ptr.
  - Outputs: one-hot grant, binary id.
  - Purely combinational.

## Test plan
- **Single request:** req_valid[2] with addr 0x40; slave asserts read_done 3 cycles after read_en with data 0xDEADBEEF, resp 00. Required: read_addr_in = 0x40, exactly one read_en pulse, rsp_valid = 4'b0100 with 0xDEADBEEF / 00 in the cycle after done.
- **Fairness:** all four req_valid held high. Grants occur in order 0,1,2,3,0 with spacing ≥ 3 cycles; no rsp_valid goes to a requester that was not granted.
- **Zero-wait slave:** read_done in the same cycle as read_en. rsp_valid follows one cycle later and the next grant comes 3 cycles after the previous one.
- **Watchdog:** TIMEOUT = 8 and the slave never asserts done. Requester 1 receives rsp_resp = 11, rsp_data = 0 at T+9. A read_done injected afterwards produces no rsp_valid.
- **Error passthrough and tie:** slave returns 10; separately, read_done coincides with the watchdog-fire cycle. The response 10 is forwarded in the first case; in the tie case the slave's data and response win.
- **Reset mid-read:** reset asserted during WAIT. The following cycle shows IDLE with all outputs 0 and rr_ptr = 0, no rsp_valid for the aborted read, and the next grant goes to the lowest-index active requester.
